// File: rtl/coverfloat_multi_ch_sampler.sv
// Multi-channel FP transaction sampler: per-channel FIFOs, round-robin check/sample sequencing.
// Optional halt-on-fail behaviour is enabled with COVERFLOAT_HALT_ON_FAIL_EN.
module coverfloat_multi_ch_sampler #(
  parameter int NUM_CH = 4,
  parameter int TXN_W  = 128,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*TXN_W-1:0] in_txn,
  output logic                    chk_req,
  output logic [TXN_W-1:0]        chk_txn,
  output logic [CH_W-1:0]         chk_ch,
  input  logic                    chk_done,
  input  logic                    chk_pass,
  output logic                    smp_req,
  input  logic                    smp_done,
  output logic [CNT_W-1:0]        txn_cnt,
  output logic [CNT_W-1:0]        fail_cnt,
  output logic                    idle,
  output logic                    halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TXN_W-1:0]  mem [NUM_CH][DEPTH];
  logic [AW-1:0]     wptr [NUM_CH];
  logic [AW-1:0]     rptr [NUM_CH];
  logic [CW-1:0]     cnt  [NUM_CH];
  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  logic [1:0]        state;
  logic [CH_W-1:0]   last_ch;
  logic [CH_W-1:0]   win_ch;
  logic              win_vld;
  logic              do_pop;
  logic              halt_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      nonempty[i] = (cnt[i] != '0);
      in_ready[i] = (cnt[i] != CW'(DEPTH));
      push[i]     = in_valid[i] & in_ready[i];
    end
  end

  // Search starts just after the last grant, so the granted channel is lowest priority.
  always_comb begin
    logic [CH_W-1:0] idx;
    win_vld = 1'b0;
    win_ch  = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(last_ch) + k) % NUM_CH);
      if (!win_vld && nonempty[idx]) begin
        win_vld = 1'b1;
        win_ch  = idx;
      end
    end
  end

  assign do_pop = (state == S_IDLE) && win_vld;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i] = do_pop && (win_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem[i][wptr[i]] <= in_txn[i*TXN_W +: TXN_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
        if (push[i] && !pop[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (pop[i] && !push[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

`ifdef COVERFLOAT_HALT_ON_FAIL_EN
  logic pass_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      chk_txn  <= '0;
      chk_ch   <= '0;
      last_ch  <= CH_W'(NUM_CH - 1);
      txn_cnt  <= '0;
      fail_cnt <= '0;
      halt_q   <= 1'b0;
`ifdef COVERFLOAT_HALT_ON_FAIL_EN
      pass_q   <= 1'b1;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (do_pop) begin
            chk_txn <= mem[win_ch][rptr[win_ch]];
            chk_ch  <= win_ch;
            last_ch <= win_ch;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (chk_done) begin
`ifdef COVERFLOAT_HALT_ON_FAIL_EN
            pass_q <= chk_pass;
`endif
            if (!chk_pass && fail_cnt != CNT_MAX)
              fail_cnt <= fail_cnt + 1'b1;
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (smp_done) begin
            if (txn_cnt != CNT_MAX) txn_cnt <= txn_cnt + 1'b1;
`ifdef COVERFLOAT_HALT_ON_FAIL_EN
            if (!pass_q) begin
              state  <= S_HALT;
              halt_q <= 1'b1;
            end else begin
              state  <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign chk_req = (state == S_CHECK);
  assign smp_req = (state == S_SAMPLE);
  assign idle    = (state == S_IDLE) && !(|nonempty);

`ifdef COVERFLOAT_HALT_ON_FAIL_EN
  assign halted = halt_q;
`else
  assign halted = 1'b0;
  logic unused_halt;
  assign unused_halt = halt_q;
`endif

endmodule
